// File: rtl/servo_pwm_decoder.sv
// Servo PWM pulse-width decoder: measures each high pulse on pwm_in and converts it
// to a signed Q10.7 angle, with range checking and loss-of-signal detection.
module servo_pwm_decoder #(
    parameter int unsigned CENTER_CYCLES  = 150_000,
    parameter int unsigned SCALE_MUL      = 40_265,
    parameter int unsigned SCALE_SHIFT    = 18,
    parameter int unsigned MIN_PULSE      = 90_000,
    parameter int unsigned MAX_PULSE      = 210_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned ANGLE_LIMIT    = 7_680
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        pwm_in,
    output logic [17:0] angle,
    output logic        angle_valid,
    output logic        pulse_err,
    output logic        signal_lost
);

    localparam logic [1:0] StArm      = 2'd0;
    localparam logic [1:0] StWaitRise = 2'd1;
    localparam logic [1:0] StHigh     = 2'd2;
    localparam logic [1:0] StCalc     = 2'd3;

    localparam logic [21:0]        MIN_W      = 22'(MIN_PULSE);
    localparam logic [21:0]        MAX_W      = 22'(MAX_PULSE);
    localparam logic [21:0]        TIMEOUT_W  = 22'(TIMEOUT_CYCLES);
    localparam logic signed [22:0] CENTER_S   = 23'(CENTER_CYCLES);
    localparam logic signed [39:0] SCALE_S    = 40'(SCALE_MUL);
    localparam logic signed [39:0] ROUND_HALF = 40'(1) << (SCALE_SHIFT - 1);
    localparam logic signed [39:0] LIM_POS    = 40'(ANGLE_LIMIT);
    localparam logic signed [39:0] LIM_NEG    = -LIM_POS;

    // Synchronizer flops are deliberately not reset so a pulse in progress at reset
    // stays visible as high and is discarded by StArm instead of looking like a rise.
    logic s1, s2, s3;
    always_ff @(posedge clock) begin
        s1 <= pwm_in;
        s2 <= s1;
        s3 <= s2;
    end

    logic rise, fall;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    logic [1:0]  state_q, state_d;
    logic [21:0] width_cnt_q, width_cnt_d;
    logic [21:0] level_cnt_q, level_cnt_d;
    logic [21:0] width_q, width_d;
    logic        pending_q, pending_d;
    logic        calc_step_q, calc_step_d;
    logic signed [39:0] prod_q, prod_d;
    logic        in_range_q, in_range_d;
    logic [17:0] angle_q, angle_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        lost_q, lost_d;

    function automatic logic [21:0] sat_inc(input logic [21:0] v);
        return (&v) ? v : v + 22'd1;
    endfunction

    logic signed [22:0] diff;
    logic signed [39:0] diff_ext;
    logic signed [39:0] rounded;
    logic signed [39:0] clamped;
    logic               timeout;

    assign diff     = $signed({1'b0, width_q}) - CENTER_S;
    assign diff_ext = {{17{diff[22]}}, diff};
    assign prod_d   = diff_ext * SCALE_S;
    assign in_range_d = (width_q >= MIN_W) && (width_q <= MAX_W);
    assign rounded  = (prod_q + ROUND_HALF) >>> SCALE_SHIFT;
    assign clamped  = (rounded > LIM_POS) ? LIM_POS : ((rounded < LIM_NEG) ? LIM_NEG : rounded);
    assign timeout  = (level_cnt_q >= TIMEOUT_W) && !(rise || fall);

    always_comb begin
        state_d     = state_q;
        width_cnt_d = width_cnt_q;
        width_d     = width_q;
        pending_d   = pending_q;
        calc_step_d = calc_step_q;
        angle_d     = angle_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        lost_d      = lost_q;
        level_cnt_d = (rise || fall) ? 22'd0 : sat_inc(level_cnt_q);

        if (!en) begin
            state_d     = StArm;
            pending_d   = 1'b0;
            calc_step_d = 1'b0;
        end else begin
            case (state_q)
                StArm: begin
                    if (!s2) state_d = StWaitRise;
                end
                StWaitRise: begin
                    // The counter starts at 1 so the rise cycle itself is included.
                    if (rise) begin
                        width_cnt_d = 22'd1;
                        state_d     = StHigh;
                    end else if (pending_q) begin
                        pending_d = 1'b0;
                        if (fall) begin
                            width_d     = width_cnt_q;
                            calc_step_d = 1'b0;
                            state_d     = StCalc;
                        end else begin
                            width_cnt_d = sat_inc(width_cnt_q);
                            state_d     = StHigh;
                        end
                    end else if (timeout && !lost_q) begin
                        // Once lost, keep waiting here so the next rise is never missed.
                        lost_d  = 1'b1;
                        state_d = StArm;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        width_d     = width_cnt_q;
                        calc_step_d = 1'b0;
                        state_d     = StCalc;
                    end else if (timeout) begin
                        lost_d  = 1'b1;
                        state_d = StArm;
                    end else begin
                        width_cnt_d = sat_inc(width_cnt_q);
                    end
                end
                default: begin
                    if (rise) begin
                        pending_d   = 1'b1;
                        width_cnt_d = 22'd1;
                    end else if (pending_q) begin
                        if (fall) pending_d = 1'b0;
                        else width_cnt_d = sat_inc(width_cnt_q);
                    end
                    if (!calc_step_q) begin
                        calc_step_d = 1'b1;
                    end else begin
                        calc_step_d = 1'b0;
                        state_d     = StWaitRise;
                        if (in_range_q) begin
                            angle_d = clamped[17:0];
                            valid_d = 1'b1;
                            lost_d  = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StArm;
            width_cnt_q <= '0;
            level_cnt_q <= '0;
            width_q     <= '0;
            pending_q   <= 1'b0;
            calc_step_q <= 1'b0;
            prod_q      <= '0;
            in_range_q  <= 1'b0;
            angle_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_cnt_q <= width_cnt_d;
            level_cnt_q <= level_cnt_d;
            width_q     <= width_d;
            pending_q   <= pending_d;
            calc_step_q <= calc_step_d;
            prod_q      <= prod_d;
            in_range_q  <= in_range_d;
            angle_q     <= angle_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
        end
    end

    assign angle       = angle_q;
    assign angle_valid = valid_q;
    assign pulse_err   = err_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with timing scaled down 200x (750 cycles = 0 deg,
// 250 cycles = 60 deg) so every scenario fits in a short run.
module tb_servo_pwm_decoder;

    localparam int unsigned T_OUT  = 12_500;
    localparam int unsigned PERIOD = 2_500;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        pwm_in = 1'b0;
    logic [17:0] angle;
    logic        angle_valid;
    logic        pulse_err;
    logic        signal_lost;

    int n_tests = 0;
    int n_fail = 0;
    logic lost_pre;

    servo_pwm_decoder #(
        .CENTER_CYCLES (750),
        .SCALE_MUL     (31_457),
        .SCALE_SHIFT   (10),
        .MIN_PULSE     (450),
        .MAX_PULSE     (1_050),
        .TIMEOUT_CYCLES(T_OUT),
        .ANGLE_LIMIT   (7_680)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .pwm_in     (pwm_in),
        .angle      (angle),
        .angle_valid(angle_valid),
        .pulse_err  (pulse_err),
        .signal_lost(signal_lost)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one pulse of `width` sampled-high clocks, then watches 10 cycles for the strobe.
    task automatic do_pulse(input string tag, input int width, input bit exp_ok,
                            input logic [17:0] exp_angle, input int low_cycles);
        logic [17:0] prev_angle;
        int first, nv, ne;
        prev_angle = angle;
        first = 0;
        nv = 0;
        ne = 0;
        @(negedge clock);
        pwm_in = 1'b1;
        for (int i = 0; i < width; i++) begin
            @(negedge clock);
            nv += int'(angle_valid);
            ne += int'(pulse_err);
        end
        pwm_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 4) lost_pre = signal_lost;
            if ((angle_valid || pulse_err) && first == 0) first = i;
            nv += int'(angle_valid);
            ne += int'(pulse_err);
        end
        check_eq({tag, " latency"}, 32'(first), 32'd5);
        check_eq({tag, " valid count"}, 32'(nv), exp_ok ? 32'd1 : 32'd0);
        check_eq({tag, " err count"}, 32'(ne), exp_ok ? 32'd0 : 32'd1);
        check_eq({tag, " angle"}, 32'(angle), 32'(exp_ok ? exp_angle : prev_angle));
        if (exp_ok) check_eq({tag, " lost"}, 32'(signal_lost), 32'd0);
        repeat ((low_cycles > 10) ? low_cycles - 10 : 0) @(negedge clock);
    endtask

    initial begin
        int nv, ne;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("reset angle", 32'(angle), 32'd0);
        check_eq("reset valid", 32'(angle_valid), 32'd0);
        check_eq("reset err", 32'(pulse_err), 32'd0);
        check_eq("reset lost", 32'(signal_lost), 32'd0);
        repeat (20) @(negedge clock);

        do_pulse("p750",  750,  1, 18'h00000, PERIOD - 750);
        do_pulse("p1000", 1000, 1, 18'h01E00, PERIOD - 1000);
        do_pulse("p500",  500,  1, 18'h3E200, PERIOD - 500);
        do_pulse("p1050", 1050, 1, 18'h01E00, PERIOD - 1050);
        do_pulse("p1051", 1051, 0, 18'h00000, PERIOD - 1051);
        do_pulse("p450",  450,  1, 18'h3E200, PERIOD - 450);
        do_pulse("p449",  449,  0, 18'h00000, PERIOD - 449);
        do_pulse("p1100", 1100, 0, 18'h00000, PERIOD - 1100);
        do_pulse("glitch", 3,   0, 18'h00000, PERIOD - 3);
        do_pulse("p800",  800,  1, 18'h00600, PERIOD - 800);
        do_pulse("p751",  751,  1, 18'h0001F, PERIOD - 751);
        do_pulse("p749",  749,  1, 18'h3FFE1, PERIOD - 749);
        do_pulse("p875",  875,  1, 18'h00F00, 10);

        // Level counter clears on the edge after the fall, so lost appears at fall + T + 4.
        repeat (T_OUT - 7) @(negedge clock);
        check_eq("lost before timeout", 32'(signal_lost), 32'd0);
        @(negedge clock);
        check_eq("lost at timeout", 32'(signal_lost), 32'd1);
        repeat (100) @(negedge clock);
        check_eq("lost held", 32'(signal_lost), 32'd1);
        do_pulse("relock", 750, 1, 18'h00000, PERIOD - 750);
        check_eq("lost until strobe", 32'(lost_pre), 32'd1);

        do_pulse("pre_rst", 1000, 1, 18'h01E00, PERIOD - 1000);
        @(negedge clock);
        pwm_in = 1'b1;
        repeat (500) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("midrst angle", 32'(angle), 32'd0);
        check_eq("midrst valid", 32'(angle_valid), 32'd0);
        check_eq("midrst err", 32'(pulse_err), 32'd0);
        check_eq("midrst lost", 32'(signal_lost), 32'd0);
        nv = 0;
        ne = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            nv += int'(angle_valid);
            ne += int'(pulse_err);
        end
        pwm_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            nv += int'(angle_valid);
            ne += int'(pulse_err);
        end
        check_eq("midrst tail valid", 32'(nv), 32'd0);
        check_eq("midrst tail err", 32'(ne), 32'd0);
        repeat (1500) @(negedge clock);
        do_pulse("post_rst", 500, 1, 18'h3E200, PERIOD - 500);

        // Dropping en mid-pulse abandons it even though en returns before the fall.
        @(negedge clock);
        pwm_in = 1'b1;
        repeat (300) @(negedge clock);
        en = 1'b0;
        repeat (5) @(negedge clock);
        en = 1'b1;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            nv += int'(angle_valid);
            ne += int'(pulse_err);
        end
        pwm_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            nv += int'(angle_valid);
            ne += int'(pulse_err);
        end
        check_eq("en drop valid", 32'(nv), 32'd0);
        check_eq("en drop err", 32'(ne), 32'd0);
        check_eq("en drop angle", 32'(angle), 32'h3E200);
        repeat (1500) @(negedge clock);
        do_pulse("post_en", 1000, 1, 18'h01E00, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
